// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 data-memory stage: instruction codes, status
// encodings, FSM state constants and small decode helpers.
package y86_pkg;

    localparam logic [3:0] IC_HALT   = 4'h0;
    localparam logic [3:0] IC_NOP    = 4'h1;
    localparam logic [3:0] IC_RRMOVQ = 4'h2;
    localparam logic [3:0] IC_IRMOVQ = 4'h3;
    localparam logic [3:0] IC_RMMOVQ = 4'h4;
    localparam logic [3:0] IC_MRMOVQ = 4'h5;
    localparam logic [3:0] IC_OPQ    = 4'h6;
    localparam logic [3:0] IC_JXX    = 4'h7;
    localparam logic [3:0] IC_CALL   = 4'h8;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_PUSHQ  = 4'hA;
    localparam logic [3:0] IC_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        SAOK = 2'd0,
        SADR = 2'd1,
        SINS = 2'd2,
        SHLT = 2'd3
    } stat_e;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    function automatic logic is_read(input logic [3:0] icode);
        return (icode == IC_MRMOVQ) || (icode == IC_RET) || (icode == IC_POPQ);
    endfunction

    function automatic logic is_write(input logic [3:0] icode);
        return (icode == IC_RMMOVQ) || (icode == IC_CALL) || (icode == IC_PUSHQ);
    endfunction

    // Stack pops address through valA; everything else that touches memory uses valE.
    function automatic logic addr_from_vala(input logic [3:0] icode);
        return (icode == IC_RET) || (icode == IC_POPQ);
    endfunction

    function automatic stat_e status_of(input logic adr_err, input logic instr_valid,
                                        input logic [3:0] icode);
        if (adr_err)
            return SADR;
        else if (!instr_valid)
            return SINS;
        else if (icode == IC_HALT)
            return SHLT;
        else
            return SAOK;
    endfunction

endpackage

// File: rtl/y86_dmem_array.sv
// Single-port synchronous word RAM with registered read (read-before-write).
module y86_dmem_array #(
    parameter int    DATA_W    = 64,
    parameter int    DEPTH     = 256,
    parameter int    AW        = 8,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/y86_dmem_stage.sv
// Clocked Y86 memory stage: one request per handshake, programmable wait states,
// registered valM/status, and a sticky halt on any non-SAOK status.
module y86_dmem_stage
    import y86_pkg::*;
#(
    parameter int    DATA_W    = 64,
    parameter int    DEPTH     = 256,
    parameter int    PC_W      = 11,
    parameter int    WAIT_CYC  = 0,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valE,
    input  logic [PC_W-1:0]   valP,
    input  logic              imem_error,
    input  logic              instr_valid,
    output logic              resp_valid,
    output logic [DATA_W-1:0] valM,
    output logic              dmem_error,
    output logic [1:0]        stat,
    output logic              halted
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]        state_reg, state_next;
    logic [3:0]        cnt_reg;
    logic              rd_reg, wr_reg;
    logic [DATA_W-1:0] addr_reg, data_reg;
    logic [3:0]        icode_reg;
    logic              imem_err_reg, instr_valid_reg;
    logic [DATA_W-1:0] valm_reg;
    logic              dmem_err_reg;
    stat_e             stat_reg;
    logic              rd_hit_reg;

    logic              dec_rd, dec_wr;
    logic [DATA_W-1:0] dec_addr, dec_data;
    logic              access_now, out_of_range, acc_err, ram_we;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        dec_rd   = is_read(icode);
        dec_wr   = is_write(icode);
        dec_addr = '0;
        dec_data = '0;
        if (addr_from_vala(icode))
            dec_addr = valA;
        else if (dec_rd || dec_wr)
            dec_addr = valE;
        if (icode == IC_RMMOVQ || icode == IC_PUSHQ)
            dec_data = valA;
        else if (icode == IC_CALL)
            dec_data = DATA_W'(valP);
    end

    // Full-width compare so large addresses fault instead of aliasing into the array.
    assign out_of_range = (addr_reg >= DATA_W'(DEPTH));
    assign access_now   = (state_reg == ST_ACCESS) && (cnt_reg == 4'd0);
    assign acc_err      = (rd_reg || wr_reg) && out_of_range;
    assign ram_we       = access_now && wr_reg && !out_of_range && !imem_err_reg;

    y86_dmem_array #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_reg[AW-1:0]),
        .wdata (data_reg),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (req_valid) state_next = ST_ACCESS;
            ST_ACCESS: if (cnt_reg == 4'd0) state_next = ST_RESP;
            ST_RESP:   state_next = (stat_reg == SAOK) ? ST_IDLE : ST_HALT;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            rd_reg          <= 1'b0;
            wr_reg          <= 1'b0;
            addr_reg        <= '0;
            data_reg        <= '0;
            icode_reg       <= '0;
            imem_err_reg    <= 1'b0;
            instr_valid_reg <= 1'b0;
            valm_reg        <= '0;
            dmem_err_reg    <= 1'b0;
            stat_reg        <= SAOK;
            rd_hit_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        rd_reg          <= dec_rd;
                        wr_reg          <= dec_wr;
                        addr_reg        <= dec_addr;
                        data_reg        <= dec_data;
                        icode_reg       <= icode;
                        imem_err_reg    <= imem_error;
                        instr_valid_reg <= instr_valid;
                        cnt_reg         <= 4'(WAIT_CYC);
                        dmem_err_reg    <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        dmem_err_reg <= acc_err;
                        rd_hit_reg   <= rd_reg && !out_of_range;
                        if (acc_err)
                            valm_reg <= '0;
                        stat_reg <= status_of(imem_err_reg || acc_err, instr_valid_reg,
                                              icode_reg);
                    end
                end
                ST_RESP: begin
                    // RAM data arrives one cycle after the access edge; fold it into the holding register.
                    if (rd_hit_reg)
                        valm_reg <= ram_rdata;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state_reg == ST_IDLE);
    assign resp_valid = (state_reg == ST_RESP);
    assign halted     = (state_reg == ST_HALT);
    assign valM       = (resp_valid && rd_hit_reg) ? ram_rdata : valm_reg;
    assign dmem_error = dmem_err_reg;
    assign stat       = stat_reg;

endmodule

// File: tb/tb_y86_dmem_stage.sv
// Scoreboard bench for y86_dmem_stage: two instances (0 and 3 wait states) driven
// with directed and random requests, checked against a word-level memory model.
module tb_y86_dmem_stage;
    import y86_pkg::*;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 256;
    localparam int PC_W   = 11;

    typedef struct {
        logic [63:0] valm;
        logic [1:0]  stat;
        logic        derr;
        int          due;
        int          id;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic        clk = 1'b0;
    logic        rst_n       [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [3:0]  icode       [2];
    logic [63:0] valA        [2];
    logic [63:0] valE        [2];
    logic [10:0] valP        [2];
    logic        imem_error  [2];
    logic        instr_valid [2];
    logic        resp_valid  [2];
    logic [63:0] valM        [2];
    logic        dmem_error  [2];
    logic [1:0]  stat        [2];
    logic        halted      [2];

    logic [63:0] mem_m  [2][256];
    logic [63:0] valm_m [2];
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          n_sent;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        y86_dmem_stage #(
            .DATA_W    (DATA_W),
            .DEPTH     (DEPTH),
            .PC_W      (PC_W),
            .WAIT_CYC  (gi * 3),
            .INIT_FILE ("")
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n[gi]),
            .req_valid   (req_valid[gi]),
            .req_ready   (req_ready[gi]),
            .icode       (icode[gi]),
            .valA        (valA[gi]),
            .valE        (valE[gi]),
            .valP        (valP[gi]),
            .imem_error  (imem_error[gi]),
            .instr_valid (instr_valid[gi]),
            .resp_valid  (resp_valid[gi]),
            .valM        (valM[gi]),
            .dmem_error  (dmem_error[gi]),
            .stat        (stat[gi]),
            .halted      (halted[gi])
        );
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h required 0x%0h", name, d, act, exp);
        end
    endtask

    // Word-level model: what the memory stage must do for one request.
    task automatic model(input int d, input logic [3:0] ic, input logic [63:0] a,
                         input logic [63:0] e, input logic [10:0] p, input logic ie,
                         input logic iv, output exp_t r);
        logic        rd, wr, bad;
        logic [63:0] addr, data;
        rd   = (ic == 4'd5) || (ic == 4'd9) || (ic == 4'd11);
        wr   = (ic == 4'd4) || (ic == 4'd8) || (ic == 4'd10);
        addr = (ic == 4'd9 || ic == 4'd11) ? a : ((rd || wr) ? e : 64'd0);
        data = (ic == 4'd4 || ic == 4'd10) ? a : ((ic == 4'd8) ? {53'd0, p} : 64'd0);
        bad  = (rd || wr) && (addr >= 64'd256);
        if (bad) begin
            valm_m[d] = 64'd0;
        end else begin
            if (wr && !ie) mem_m[d][addr[7:0]] = data;
            if (rd) valm_m[d] = mem_m[d][addr[7:0]];
        end
        r.valm = valm_m[d];
        r.derr = bad;
        if (ie || bad)  r.stat = SADR;
        else if (!iv)   r.stat = SINS;
        else if (ic == 4'd0) r.stat = SHLT;
        else            r.stat = SAOK;
        r.due = 0;
        r.id  = 0;
    endtask

    task automatic send(input int d, input logic [3:0] ic, input logic [63:0] a,
                        input logic [63:0] e, input logic [10:0] p, input logic ie,
                        input logic iv);
        int   t;
        exp_t r;
        t = 0;
        @(negedge clk);
        while (!req_ready[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[d]) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_ready_timeout dut%0d: got 0 required 1", d);
            return;
        end
        icode[d] = ic; valA[d] = a; valE[d] = e; valP[d] = p;
        imem_error[d] = ie; instr_valid[d] = iv; req_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        // Scramble everything after the accept edge; the stage must ignore it.
        req_valid[d] = 1'b0;
        valA[d] = {$urandom, $urandom};
        valE[d] = {$urandom, $urandom};
        valP[d] = 11'($urandom);
        icode[d] = 4'($urandom);
        imem_error[d] = 1'($urandom);
        instr_valid[d] = 1'($urandom);
        model(d, ic, a, e, p, ie, iv, r);
        r.due = cyc + wait_of(d) + 1;
        r.id  = n_sent++;
        $display("req  dut%0d id=%0d icode=%0d valA=0x%0h valE=0x%0h valP=0x%0h ie=%0d iv=%0d",
                 d, r.id, ic, a, e, p, ie, iv);
        if (d == 0) q0.push_back(r);
        else        q1.push_back(r);
    endtask

    task automatic drain(input int d);
        int t;
        t = 0;
        while (qsize(d) != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("drain", d, 64'(qsize(d)), 64'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input int d);
        chk("rst_req_ready", d, 64'(req_ready[d]), 64'd1);
        chk("rst_resp_valid", d, 64'(resp_valid[d]), 64'd0);
        chk("rst_valM", d, valM[d], 64'd0);
        chk("rst_dmem_error", d, 64'(dmem_error[d]), 64'd0);
        chk("rst_stat", d, 64'(stat[d]), 64'd0);
        chk("rst_halted", d, 64'(halted[d]), 64'd0);
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst_n[d] = 1'b0;
        @(negedge clk);
        check_reset_vals(d);
        rst_n[d] = 1'b1;
        valm_m[d] = 64'd0;
    endtask

    task automatic expect_halt(input int d);
        drain(d);
        chk("halted", d, 64'(halted[d]), 64'd1);
        chk("halt_req_ready", d, 64'(req_ready[d]), 64'd0);
    endtask

    // Cycle counter: value equals the number of rising edges seen so far.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: pop one expectation per response pulse and compare.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst_n[k] === 1'b1 && resp_valid[k] === 1'b1) begin
                    if (qsize(k) == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_resp dut%0d: got resp_valid=1 required 0", k);
                    end else begin
                        r = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk("valM", k, valM[k], r.valm);
                        chk("stat", k, 64'(stat[k]), 64'(r.stat));
                        chk("dmem_error", k, 64'(dmem_error[k]), 64'(r.derr));
                        chk("latency", k, 64'(cyc), 64'(r.due));
                        chk("resp_req_ready", k, 64'(req_ready[k]), 64'd0);
                        $display("resp dut%0d id=%0d valM=0x%0h stat=%0d dmem_error=%0d cyc=%0d",
                                 k, r.id, valM[k], stat[k], dmem_error[k], cyc);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ic;
        logic [63:0] addr, data;
        int          pick;
        logic [3:0]  ops [8];
        n_checks = 0; n_fail = 0; n_sent = 0;
        ops[0] = 4'd4; ops[1] = 4'd5; ops[2] = 4'd8;  ops[3] = 4'd9;
        ops[4] = 4'd10; ops[5] = 4'd11; ops[6] = 4'd6; ops[7] = 4'd2;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; icode[d] = 4'd0;
            valA[d] = '0; valE[d] = '0; valP[d] = '0;
            imem_error[d] = 1'b0; instr_valid[d] = 1'b1; valm_m[d] = '0;
            for (int i = 0; i < 256; i++) mem_m[d][i] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Basic write, read-back, call-push of valP
        send(0, 4'd4, 64'h55, 64'd8, 11'd0, 1'b0, 1'b1);
        drain(0);
        chk("ready_after_resp", 0, 64'(req_ready[0]), 64'd1);
        send(0, 4'd5, 64'h1234, 64'd8, 11'd0, 1'b0, 1'b1);
        send(0, 4'd8, 64'h9999, 64'd3, 11'h7FF, 1'b0, 1'b1);
        send(0, 4'd5, 64'd0, 64'd3, 11'd0, 1'b0, 1'b1);
        drain(0);

        // Preload words 0..15, then random traffic inside that window
        for (int i = 0; i < 16; i++)
            send(0, 4'd4, {$urandom, $urandom}, 64'(i), 11'd0, 1'b0, 1'b1);
        for (int n = 0; n < 150; n++) begin
            pick = $urandom_range(0, 7);
            ic   = ops[pick];
            addr = 64'($urandom_range(0, 15));
            data = {$urandom, $urandom};
            if (ic == 4'd9 || ic == 4'd11)
                send(0, ic, addr, data, 11'($urandom), 1'b0, 1'b1);
            else
                send(0, ic, data, addr, 11'($urandom), 1'b0, 1'b1);
        end
        drain(0);

        // Out-of-range pop halts; further requests ignored
        send(0, 4'd11, 64'd256, 64'd1, 11'd0, 1'b0, 1'b1);
        expect_halt(0);
        chk("halt_valM", 0, valM[0], 64'd0);
        for (int n = 0; n < 6; n++) begin
            icode[0] = 4'd4; valE[0] = 64'd0; valA[0] = 64'hDEAD; req_valid[0] = 1'b1;
            @(negedge clk);
            chk("halt_ignore_ready", 0, 64'(req_ready[0]), 64'd0);
        end
        req_valid[0] = 1'b0;
        do_reset(0);
        send(0, 4'd5, 64'd0, 64'd0, 11'd0, 1'b0, 1'b1);

        // High address bits never wrap
        send(0, 4'd5, 64'd0, 64'h1 << 40, 11'd0, 1'b0, 1'b1);
        expect_halt(0);
        do_reset(0);

        // Illegal instruction, HALT, fetch error on a store
        send(0, 4'd6, 64'd1, 64'd2, 11'd0, 1'b0, 1'b0);
        expect_halt(0);
        do_reset(0);
        send(0, 4'd0, 64'd0, 64'd0, 11'd0, 1'b0, 1'b1);
        expect_halt(0);
        do_reset(0);
        send(0, 4'd4, 64'hABCDEF, 64'd12, 11'd0, 1'b1, 1'b1);
        expect_halt(0);
        do_reset(0);
        send(0, 4'd5, 64'd0, 64'd12, 11'd0, 1'b0, 1'b1);
        drain(0);

        // Reset during ACCESS abandons the store to word 10
        @(negedge clk);
        chk("pre_abort_ready", 0, 64'(req_ready[0]), 64'd1);
        icode[0] = 4'd4; valA[0] = 64'hAA; valE[0] = 64'd10; req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst_n[0] = 1'b0;
        @(negedge clk);
        check_reset_vals(0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        valm_m[0] = 64'd0;
        send(0, 4'd5, 64'd0, 64'd10, 11'd0, 1'b0, 1'b1);
        drain(0);

        // Three wait states: latency and input-hold behaviour
        send(1, 4'd4, 64'h1234_5678, 64'd2, 11'd0, 1'b0, 1'b1);
        send(1, 4'd9, 64'd2, 64'd7, 11'd0, 1'b0, 1'b1);
        send(1, 4'd10, 64'hCAFE, 64'd5, 11'd0, 1'b0, 1'b1);
        send(1, 4'd11, 64'd5, 64'd0, 11'd0, 1'b0, 1'b1);
        send(1, 4'd8, 64'd0, 64'd6, 11'h123, 1'b0, 1'b1);
        send(1, 4'd5, 64'd0, 64'd6, 11'd0, 1'b0, 1'b1);
        drain(1);

        chk("q0_empty", 0, 64'(q0.size()), 64'd0);
        chk("q1_empty", 1, 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
